// File: rtl/key_entry_if.sv
// -----------------------------------------------------------------------------
// key_entry_if
//
// Groups the keypad/timebase inputs and the key-buffer/display control outputs
// of the alarm-clock key entry controller.
//
// Signal summary:
//   one_second    : single-cycle pulse once per second from the timebase
//   key[3:0]      : debounced keypad code (0..9 digit, A ALARM, B TIME, F NOKEY)
//   shift         : one-cycle pulse, shift key into the 4-digit key buffer
//   load_alarm    : one-cycle pulse, copy key buffer into the alarm register
//   load_new_time : one-cycle pulse, copy key buffer into the time counter
//   show_alarm    : level, display selects the alarm register
//   show_new_time : level, display selects the key buffer
//   digit_count   : digits entered in the current entry, saturating at 4
//   state_dbg     : current controller state, for observation only
//
// Handshake semantics: there is no valid/ready pair on this interface. key is a
// level that is sampled on every rising clock edge; shift, load_alarm and
// load_new_time are single-cycle strobes that the consumer must act on in the
// cycle they are high (no back-pressure is possible).
//
// Modports:
//   master : keypad/timebase side (drives one_second/key, observes the rest)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface key_entry_if;
    logic       one_second;
    logic [3:0] key;
    logic       shift;
    logic       load_alarm;
    logic       load_new_time;
    logic       show_alarm;
    logic       show_new_time;
    logic [2:0] digit_count;
    logic [2:0] state_dbg;

    modport master (
        output one_second,
        output key,
        input  shift,
        input  load_alarm,
        input  load_new_time,
        input  show_alarm,
        input  show_new_time,
        input  digit_count,
        input  state_dbg
    );

    modport slave (
        input  one_second,
        input  key,
        output shift,
        output load_alarm,
        output load_new_time,
        output show_alarm,
        output show_new_time,
        output digit_count,
        output state_dbg
    );
endinterface : key_entry_if

// File: rtl/key_entry_fsm.sv
// -----------------------------------------------------------------------------
// key_entry_fsm
//
// Sequencing controller for the 4-digit key buffer of the alarm clock. Each
// digit press produces exactly one shift pulse (the buffer therefore holds the
// last 4 digits entered). After at least 4 digits, ALARM commits the buffer to
// the alarm register and TIME commits it to the time counter. An entry is
// abandoned after TIMEOUT_SEC seconds of keypad inactivity.
//
// Parameters:
//   TIMEOUT_SEC : one_second pulses of inactivity before an entry is abandoned
//                 (legal range 1..15)
//
// Ports:
//   clock : system clock, all state changes on the rising edge
//   reset : asynchronous, active-low reset
//   bus   : key_entry_if slave modport (keypad inputs, buffer/display outputs,
//           state observation)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module key_entry_fsm #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic        clock,
    input  logic        reset,
    key_entry_if.slave  bus
);

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_ENTRY  = 3'd1,
        KEY_STORED = 3'd2,
        KEY_WAITED = 3'd3,
        SHOW_ALARM = 3'd4
    } state_t;

    localparam logic [3:0] KEY_ALARM = 4'hA;
    localparam logic [3:0] KEY_TIME  = 4'hB;
    localparam logic [3:0] TMO_LAST  = 4'(TIMEOUT_SEC - 1);
    localparam logic [2:0] DIGITS_FULL = 3'd4;

    state_t     state_q, state_d;
    logic [2:0] digit_count_q, digit_count_d;
    logic [3:0] tmo_q, tmo_d;
    logic       shift_q, shift_d;
    logic       load_alarm_q, load_alarm_d;
    logic       load_new_time_q, load_new_time_d;
    logic       show_alarm_q, show_alarm_d;
    logic       show_new_time_q, show_new_time_d;

    // Key decode. Codes C, D, E are unused by the keypad and behave as NOKEY.
    logic key_digit;
    logic key_alarm;
    logic key_time;
    logic key_none;

    always_comb begin
        key_digit = (bus.key <= 4'd9);
        key_alarm = (bus.key == KEY_ALARM);
        key_time  = (bus.key == KEY_TIME);
        key_none  = !(key_digit || key_alarm || key_time);
    end

    // Inactivity timer only runs while an entry is waiting on the user.
    // Reaching the limit wins over any key sampled in the same cycle.
    logic counting;
    logic timeout_hit;

    always_comb begin
        counting    = (state_q == KEY_STORED) || (state_q == KEY_WAITED);
        timeout_hit = counting && bus.one_second && (tmo_q == TMO_LAST);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        digit_count_d   = digit_count_q;
        tmo_d           = 4'd0;
        load_alarm_d    = 1'b0;
        load_new_time_d = 1'b0;

        if (counting && bus.one_second) begin
            tmo_d = tmo_q + 4'd1;
        end else if (counting) begin
            tmo_d = tmo_q;
        end

        unique case (state_q)
            SHOW_TIME: begin
                if (key_digit) begin
                    state_d       = KEY_ENTRY;
                    digit_count_d = 3'd1;
                end else if (key_alarm) begin
                    state_d = SHOW_ALARM;
                end
            end

            // One cycle only: the shift strobe is high here while the digit is
            // still on the key lines, so the buffer captures it.
            KEY_ENTRY: begin
                state_d = KEY_STORED;
            end

            // Wait for release so a held digit shifts only once.
            KEY_STORED: begin
                if (timeout_hit) begin
                    state_d = SHOW_TIME;
                end else if (key_none) begin
                    state_d = KEY_WAITED;
                end
            end

            KEY_WAITED: begin
                if (timeout_hit) begin
                    state_d = SHOW_TIME;
                end else if (key_digit) begin
                    state_d       = KEY_ENTRY;
                    digit_count_d = (digit_count_q == DIGITS_FULL) ?
                                    DIGITS_FULL : digit_count_q + 3'd1;
                end else if (key_alarm || key_time) begin
                    // A short entry is simply abandoned without loading.
                    state_d         = SHOW_TIME;
                    load_alarm_d    = key_alarm && (digit_count_q == DIGITS_FULL);
                    load_new_time_d = key_time  && (digit_count_q == DIGITS_FULL);
                end
            end

            // Display follows the held ALARM button.
            SHOW_ALARM: begin
                if (key_none) begin
                    state_d = SHOW_TIME;
                end
            end

            default: begin
                state_d = SHOW_TIME;
            end
        endcase

        if (timeout_hit) begin
            tmo_d = 4'd0;
        end

        // Level outputs and the shift strobe are decoded from the next state
        // so that they line up with the state register.
        shift_d         = (state_d == KEY_ENTRY);
        show_new_time_d = (state_d == KEY_STORED) || (state_d == KEY_WAITED);
        show_alarm_d    = (state_d == SHOW_ALARM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= SHOW_TIME;
            digit_count_q   <= 3'd0;
            tmo_q           <= 4'd0;
            shift_q         <= 1'b0;
            load_alarm_q    <= 1'b0;
            load_new_time_q <= 1'b0;
            show_alarm_q    <= 1'b0;
            show_new_time_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            digit_count_q   <= digit_count_d;
            tmo_q           <= tmo_d;
            shift_q         <= shift_d;
            load_alarm_q    <= load_alarm_d;
            load_new_time_q <= load_new_time_d;
            show_alarm_q    <= show_alarm_d;
            show_new_time_q <= show_new_time_d;
        end
    end

    always_comb begin
        bus.shift         = shift_q;
        bus.load_alarm    = load_alarm_q;
        bus.load_new_time = load_new_time_q;
        bus.show_alarm    = show_alarm_q;
        bus.show_new_time = show_new_time_q;
        bus.digit_count   = digit_count_q;
        bus.state_dbg     = state_q;
    end

endmodule : key_entry_fsm

// File: tb/tb_key_entry_fsm.sv
// -----------------------------------------------------------------------------
// tb_key_entry_fsm
//
// Directed scenarios followed by randomized key/one_second traffic. A
// behavioural model of the key-entry rules predicts every output each cycle;
// predictions go through an expected queue and are compared one cycle-slot
// later, 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_key_entry_fsm;

    localparam int T = 10;
    localparam logic [3:0] K_ALARM = 4'hA;
    localparam logic [3:0] K_TIME  = 4'hB;
    localparam logic [3:0] K_NONE  = 4'hF;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    key_entry_if bus();

    key_entry_fsm #(.TIMEOUT_SEC(T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    int shift_seen = 0;
    int la_seen    = 0;
    int lt_seen    = 0;

    // ---------------- reference model ----------------
    // Entry is described as "an entry is open", "waiting for the key to be
    // released", "this is the shift cycle", plus a seconds-of-silence count.
    bit m_entry, m_wait_rel, m_shift, m_alarm, m_la, m_lt;
    int m_cnt, m_secs;

    task automatic model_reset();
        m_entry = 0; m_wait_rel = 0; m_shift = 0; m_alarm = 0;
        m_la = 0; m_lt = 0; m_cnt = 0; m_secs = 0;
    endtask

    task automatic model_step(input logic [3:0] k, input logic os);
        bit digit, alarm, tm, nokey;
        digit = (k <= 4'd9);
        alarm = (k == K_ALARM);
        tm    = (k == K_TIME);
        nokey = !(digit || alarm || tm);
        m_la = 0;
        m_lt = 0;
        if (m_shift) begin
            m_shift = 0; m_wait_rel = 1; m_secs = 0;
        end else if (m_entry) begin
            if (os && m_secs == T - 1) begin
                m_entry = 0; m_secs = 0;
            end else begin
                if (os) m_secs++;
                if (m_wait_rel) begin
                    if (nokey) m_wait_rel = 0;
                end else if (digit) begin
                    m_cnt   = (m_cnt < 4) ? m_cnt + 1 : 4;
                    m_shift = 1;
                end else if (alarm || tm) begin
                    m_entry = 0; m_secs = 0;
                    if (m_cnt == 4) begin
                        m_la = alarm; m_lt = tm;
                    end
                end
            end
        end else if (m_alarm) begin
            if (nokey) m_alarm = 0;
        end else if (digit) begin
            m_entry = 1; m_shift = 1; m_cnt = 1;
        end else if (alarm) begin
            m_alarm = 1;
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [2:0] c;
        c = 3'(m_cnt);
        return {m_shift, m_la, m_lt, m_alarm, (m_entry && !m_shift), c};
    endfunction

    function automatic logic [7:0] observed();
        return {bus.shift, bus.load_alarm, bus.load_new_time, bus.show_alarm,
                bus.show_new_time, bus.digit_count};
    endfunction

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic [3:0] k, input logic os);
        logic [7:0] e;
        bus.key = k;
        bus.one_second = os;
        @(posedge clock);
        if (reset) begin
            model_step(k, os);
            exp_q.push_back(model_out());
        end
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("outputs{shift,la,lt,sa,sn,dc}", observed(), e);
        end
        if (bus.shift) shift_seen++;
        if (bus.load_alarm) la_seen++;
        if (bus.load_new_time) lt_seen++;
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        repeat (hold) step(k, 1'b0);
        repeat (gap) step(K_NONE, 1'b0);
    endtask

    task automatic clear_counts();
        shift_seen = 0; la_seen = 0; lt_seen = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] k;
        int hold;
        bus.key = K_NONE;
        bus.one_second = 1'b0;
        model_reset();
        #1;
        check_eq("reset_state", {24'd0, observed()}, 32'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;

        // Reset dropped mid-entry (KEY_WAITED, three digits)
        press(4'd1, 5, 3);
        press(4'd2, 5, 3);
        press(4'd3, 5, 3);
        check_eq("mid_entry_count", bus.digit_count, 3);
        #2 reset = 1'b0;
        #1;
        check_eq("async_reset_outputs", {24'd0, observed()}, 32'd0);
        check_eq("async_reset_state", bus.state_dbg, 0);
        model_reset();
        repeat (2) step(K_NONE, 1'b0);
        reset = 1'b1;
        repeat (2) step(K_NONE, 1'b0);
        check_eq("post_reset_show_new", bus.show_new_time, 0);

        // 1,2,3,0 then TIME
        clear_counts();
        press(4'd1, 5, 3);
        press(4'd2, 5, 3);
        press(4'd3, 5, 3);
        press(4'd0, 5, 3);
        press(K_TIME, 3, 3);
        check_eq("time_shifts", shift_seen, 4);
        check_eq("time_load_new", lt_seen, 1);
        check_eq("time_load_alarm", la_seen, 0);
        check_eq("time_digits", bus.digit_count, 4);

        // 0,7,0,0 then ALARM held 10 cycles
        clear_counts();
        press(4'd0, 5, 3);
        press(4'd7, 5, 3);
        press(4'd0, 5, 3);
        press(4'd0, 5, 3);
        press(K_ALARM, 10, 0);
        check_eq("alarm_load", la_seen, 1);
        check_eq("alarm_no_time", lt_seen, 0);
        check_eq("alarm_held_show", bus.show_alarm, 1);
        press(K_NONE, 3, 0);
        check_eq("alarm_released_show", bus.show_alarm, 0);

        // 5,9 then ALARM: aborted
        clear_counts();
        press(4'd5, 5, 3);
        press(4'd9, 5, 3);
        press(K_ALARM, 1, 3);
        check_eq("short_no_load", la_seen + lt_seen, 0);
        check_eq("short_digits", bus.digit_count, 2);
        check_eq("short_idle_state", bus.state_dbg, 0);

        // Timeout after 10 silent seconds
        clear_counts();
        press(4'd4, 2, 2);
        for (int i = 1; i <= T; i++) begin
            step(K_NONE, 1'b1);
            if (i == T - 1) check_eq("before_timeout_show_new", bus.show_new_time, 1);
            step(K_NONE, 1'b0);
        end
        check_eq("after_timeout_show_new", bus.show_new_time, 0);
        check_eq("timeout_no_load", la_seen + lt_seen, 0);

        // Digit coincident with the final second: timeout wins, no shift
        clear_counts();
        press(4'd4, 2, 2);
        for (int i = 1; i < T; i++) step(K_NONE, 1'b1);
        step(4'd7, 1'b1);
        step(K_NONE, 1'b0);
        check_eq("coincident_digit_shifts", shift_seen, 1);
        check_eq("coincident_show_new", bus.show_new_time, 0);

        // Long hold, then six digits with saturation
        clear_counts();
        press(4'd8, 100, 3);
        check_eq("long_hold_shifts", shift_seen, 1);
        clear_counts();
        for (int d = 1; d <= 6; d++) press(4'(d), 3, 2);
        press(K_TIME, 2, 2);
        check_eq("six_shifts", shift_seen, 6);
        check_eq("six_load_new", lt_seen, 1);
        check_eq("six_digits_sat", bus.digit_count, 4);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: k = 4'($urandom_range(0, 9));
                4:          k = K_ALARM;
                5:          k = K_TIME;
                6:          k = 4'($urandom_range(12, 14));
                default:    k = K_NONE;
            endcase
            hold = $urandom_range(1, 6);
            repeat (hold) step(k, ($urandom_range(0, 5) == 0));
        end

        check_eq("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_key_entry_fsm

// File: doc/key_entry_fsm.md
Name: key_entry_fsm

Overview:
- Sequencing controller for the 4-digit key buffer in the alarm clock.
- Decodes the debounced keypad code and issues one shift pulse per digit press, so the buffer captures the last 4 digits entered.
- Commits the buffer as the alarm time or as the new current time.
- Drives the display-select strobes and abandons an entry after a period of keypad inactivity.

Parameters:
- TIMEOUT_SEC, 10, number of one_second pulses of inactivity in entry mode before the entry is abandoned; legal range 1..15.

Ports:
- clock, input, 1, system clock; all state changes on rising edge.
- reset, input, 1, asynchronous, active-low; forces reset state immediately when low.
- one_second, input, 1, single-cycle pulse once per second from the timebase.
- key, input, 4, debounced, synchronised keypad code: 0..9 digit, 4'hA ALARM, 4'hB TIME, 4'hF NOKEY; other codes are treated as NOKEY.
- shift, output, 1, one-cycle pulse that shifts key into the key buffer.
- load_alarm, output, 1, one-cycle pulse that copies the key buffer into the alarm register.
- load_new_time, output, 1, one-cycle pulse that copies the key buffer into the time counter.
- show_alarm, output, 1, level; display selects the alarm register.
- show_new_time, output, 1, level; display selects the key buffer.
- digit_count, output, 3, digits entered in this entry, saturating at 4.

Behaviour:
- Reset (reset low, asynchronous):
  - state = SHOW_TIME.
  - All outputs 0, digit_count 0, timeout counter 0.
  - Reset low mid-entry discards the entry; no load pulse is issued.
- States:
  - SHOW_TIME: idle; all level outputs 0.
  - KEY_ENTRY: single cycle; shift = 1.
  - KEY_STORED: show_new_time = 1; key still held.
  - KEY_WAITED: show_new_time = 1; key released.
  - SHOW_ALARM: show_alarm = 1.
- Transitions from SHOW_TIME:
  - key 0..9 -> KEY_ENTRY; digit_count <= 1.
  - key ALARM -> SHOW_ALARM.
  - TIME or NOKEY -> stay.
- Transitions from KEY_ENTRY:
  - Always -> KEY_STORED.
  - Timeout counter cleared.
- Transitions from KEY_STORED:
  - key NOKEY -> KEY_WAITED.
  - Timeout reached -> SHOW_TIME, no load.
  - Otherwise stay.
- Transitions from KEY_WAITED:
  - key 0..9 -> KEY_ENTRY; digit_count <= min(digit_count+1, 4).
  - ALARM with digit_count == 4 -> SHOW_TIME, load_alarm pulse.
  - TIME with digit_count == 4 -> SHOW_TIME, load_new_time pulse.
  - ALARM/TIME with digit_count < 4 -> SHOW_TIME, no load (abort).
  - Timeout reached -> SHOW_TIME, no load.
- Transitions from SHOW_ALARM:
  - key NOKEY -> SHOW_TIME.
  - Otherwise stay; display follows the held button.
- Output timing:
  - All outputs are registered.
  - shift is high exactly one clock, in the cycle after the digit is first sampled.
  - The key code is still held during that cycle and is what the buffer captures.
  - load_alarm / load_new_time are high exactly one clock, in the cycle after the ALARM/TIME code is sampled.
- Pulse exclusivity: shift, load_alarm and load_new_time are mutually exclusive; never high 2 consecutive cycles.
- One shift per press: a digit held for N cycles produces one shift. A new shift requires NOKEY to be seen first (KEY_STORED -> KEY_WAITED).
- Timeout counter:
  - Counts one_second pulses only in KEY_STORED and KEY_WAITED.
  - Cleared in every other state.
  - "Timeout reached" = counter == TIMEOUT_SEC-1 and one_second high; takes priority over key in the same cycle.
- digit_count:
  - Holds its value after returning to SHOW_TIME until the next entry starts.
  - Cleared by reset only.
- Held codes on entry to SHOW_TIME:
  - ALARM held on return after load_alarm goes straight to SHOW_ALARM. This is accepted behaviour.
  - TIME held is ignored.
- one_second coincident with state change: a pulse counts only if sampled in a counting state.

Test Plan:
- Reset low mid-KEY_WAITED with digit_count=3 -> all outputs 0 asynchronously; after reset high, SHOW_TIME with show_new_time=0.
- Press 1,2,3,0 (each held 5 cycles, NOKEY 3 cycles between), then TIME -> exactly 4 shift pulses, each 1 cycle after press start; digit_count=4; one load_new_time pulse; show_new_time falls the same cycle.
- Press 0,7,0,0 then ALARM -> one load_alarm pulse, no load_new_time. ALARM held 10 cycles afterwards -> show_alarm=1 until NOKEY, then 0.
- Press 5,9 then ALARM -> no load pulse; SHOW_TIME; digit_count=2.
- Press 4, release, then 10 one_second pulses with NOKEY -> return to SHOW_TIME on the 10th pulse; no load. Variant with a digit coincident with the 10th pulse -> no shift.
- Digit 8 held 100 cycles -> exactly one shift. Six digits then TIME -> 6 shifts, digit_count saturates at 4, one load_new_time.
